deal_cards: RTL and testbench
=============================

Name: deal_cards

Overview:
- Initiator side of the single-card draw handshake (draw_one / ready / done / drawn_card_idx).
- Deals `req_num` cards into a hand for game setup or multi-card penalties.
- Owns the working pool bitmap fed to the drawer's `available_card`, and clears each drawn bit before requesting the next card.
- Sits in GameControl, between the game FSM and the draw responder.

Parameters:
- DECK_SIZE, 106, number of card slots / bitmap width
- IDX_W, 7, width of a card index
- CNT_W, 5, width of the requested-card count

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- interboard_rst  in  1  synchronous active-high soft reset from the inter-board link; same effect as rst
- start  in  1  one-pulse request to deal; sampled in IDLE only
- req_num  in  CNT_W  number of cards to deal, latched on start
- pool_in  in  DECK_SIZE  pool snapshot, latched on start
- draw_ready  in  1  responder idle
- draw_done  in  1  responder one-cycle completion
- drawn_card_idx  in  IDX_W  responder result, valid while draw_done=1
- draw_one  out  1  one-cycle draw request to responder
- available_card  out  DECK_SIZE  working pool bitmap driven to responder
- hand  out  DECK_SIZE  bitmap of cards dealt in this operation
- dealt_cnt  out  CNT_W  cards dealt so far
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky until next start; set on empty pool, invalid index, or timeout

Behaviour:
- Reset (rst low, or interboard_rst high at the clock edge): state IDLE; draw_one=0, done=0, busy=0, err=0, dealt_cnt=0, hand=0, available_card=0.
- States: IDLE, REQ, WAIT, COMMIT, FIN. All outputs are registered.
- IDLE:
  - On start: latch available_card<=pool_in, target<=req_num; clear hand, dealt_cnt and err.
  - If req_num==0, go to FIN; otherwise go to REQ.
  - start in any other state is ignored.
- REQ:
  - If available_card==0: set err and go to FIN.
  - Otherwise, when draw_ready=1: drive draw_one=1 for exactly one cycle and go to WAIT.
  - draw_one is never asserted while draw_ready=0.
- WAIT:
  - Hold until draw_done=1, then capture drawn_card_idx into idx_q and go to COMMIT.
  - Any draw_done outside WAIT is ignored.
- COMMIT:
  - Valid index (idx_q < DECK_SIZE and available_card[idx_q]==1): clear available_card[idx_q], set hand[idx_q], increment dealt_cnt.
  - Invalid index (e.g. the 110 sentinel): set err and go to FIN without modifying the bitmaps.
  - After a valid commit: if dealt_cnt+1==target go to FIN, else go to REQ.
  - available_card is updated in COMMIT, so the pool seen by the responder for the next request always excludes the previous card.
- FIN: done=1 for one cycle, then return to IDLE. hand, dealt_cnt, err and available_card hold their values until the next start.
- Latency per card: minimum 3 cycles of this block (REQ to WAIT to COMMIT), plus responder time.
- Reset mid-operation returns to IDLE immediately. A draw already in flight at the responder is dropped, because the responder shares interboard_rst.
- Width rules:
  - dealt_cnt saturates at target and never wraps.
  - req_num greater than DECK_SIZE is clamped to DECK_SIZE.
  - Dealing stops early with err if the pool empties first.

Optional Feature:
- Macro DEAL_TIMEOUT_EN.
- Defined: a 12-bit watchdog counter runs in WAIT and clears on entry to WAIT. At 4095 cycles without draw_done, set err and go to FIN; a late draw_done is then ignored.
- Undefined: no watchdog, and WAIT waits indefinitely.

Decomposition:
- Shared GameControl package holds DECK_SIZE, IDX_W, CNT_W, the state encodings, the invalid-index sentinel 110, and the timeout limit 4095.
- One sub-module, deal_watchdog: counter with clear/enable inputs and an expire output. It is instantiated only under DEAL_TIMEOUT_EN.

Test Plan:
- pool_in all ones, req_num=14, behavioural responder returning idx 0,1,…,13 → 14 draw_one pulses; hand[13:0]=all ones; available_card[13:0]=0; dealt_cnt=14; single done; err=0.
- pool_in has only bits 5 and 77 set, req_num=3 → two cards dealt (5 and 77), then REQ sees an empty pool; err=1, dealt_cnt=2, done pulses once.
- req_num=0 → done exactly 2 cycles after start, no draw_one, hand=0.
- Responder returns idx 110, then in a second run returns a card already cleared → err=1 at COMMIT in both cases; bitmaps unchanged by the bad index.
- draw_ready held low for 20 cycles in REQ → draw_one stays 0; pulses exactly once, one cycle after draw_ready rises.
- rst driven low in WAIT, asynchronous to clk → outputs reach reset values immediately; a following start with req_num=1 completes normally.
- With DEAL_TIMEOUT_EN: responder never asserts done → err=1 and done pulse 4095 cycles after entering WAIT.

Source files
------------

// File: rtl/deal_cards_pkg.sv
// Shared GameControl constants and state encoding for the card-dealing initiator.
// The optional WAIT watchdog in deal_cards is enabled by defining DEAL_TIMEOUT_EN.
package deal_cards_pkg;

  localparam int unsigned DeckSize     = 106;
  localparam int unsigned IdxW         = 7;
  localparam int unsigned CntW         = 5;
  localparam int unsigned WdW          = 12;
  localparam int unsigned InvalidIdx   = 110;
  localparam int unsigned TimeoutLimit = 4095;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StCommit,
    StFin
  } deal_state_e;

  // Requests larger than the deck can never be satisfied, so cap them at the deck size.
  function automatic logic [CntW-1:0] clamp_count(input logic [CntW-1:0] n);
    int unsigned w;
    w = 32'(n);
    if (w > DeckSize) return CntW'(DeckSize);
    return n;
  endfunction

endpackage

// File: rtl/deal_watchdog.sv
// WAIT-state watchdog: counts enabled cycles since the last clear and flags expiry.
// Only instantiated by deal_cards when DEAL_TIMEOUT_EN is defined.
module deal_watchdog
  import deal_cards_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  logic [WdW-1:0] cnt_q, cnt_d;

  // Expires on the TimeoutLimit-th enabled cycle (count starts at 0 on the first one).
  assign expire_o = en_i && (cnt_q == WdW'(TimeoutLimit - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/deal_cards.sv
// Deals a requested number of cards through the single-card draw handshake.
// Define DEAL_TIMEOUT_EN to abort a draw that never completes (see deal_watchdog).
module deal_cards
  import deal_cards_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                interboard_rst_i,
  input  logic                start_i,
  input  logic [CntW-1:0]     req_num_i,
  input  logic [DeckSize-1:0] pool_in_i,
  input  logic                draw_ready_i,
  input  logic                draw_done_i,
  input  logic [IdxW-1:0]     drawn_card_idx_i,
  output logic                draw_one_o,
  output logic [DeckSize-1:0] available_card_o,
  output logic [DeckSize-1:0] hand_o,
  output logic [CntW-1:0]     dealt_cnt_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  deal_state_e         state_q, state_d;
  logic [CntW-1:0]     target_q, target_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DeckSize-1:0] avail_q, avail_d;
  logic [DeckSize-1:0] hand_q, hand_d;
  logic                err_q, err_d;
  logic                draw_one_q, draw_one_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                idx_valid;
  logic                wd_expire;

`ifdef DEAL_TIMEOUT_EN
  deal_watchdog u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q != StWait),
    .en_i     (state_q == StWait),
    .expire_o (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  assign idx_valid = (idx_q < IdxW'(DeckSize)) && avail_q[idx_q];

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    avail_d    = avail_q;
    hand_d     = hand_q;
    err_d      = err_q;
    draw_one_d = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          avail_d  = pool_in_i;
          target_d = clamp_count(req_num_i);
          hand_d   = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = (req_num_i == '0) ? StFin : StReq;
        end
      end
      StReq: begin
        if (avail_q == '0) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else if (draw_ready_i) begin
          draw_one_d = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        // A completion wins over a watchdog expiry in the same cycle.
        if (draw_done_i) begin
          idx_d   = drawn_card_idx_i;
          state_d = StCommit;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = StFin;
        end
      end
      StCommit: begin
        if (idx_valid) begin
          avail_d[idx_q] = 1'b0;
          hand_d[idx_q]  = 1'b1;
          if (cnt_q != target_q) cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q + 1'b1 == target_q) ? StFin : StReq;
        end else begin
          err_d   = 1'b1;
          state_d = StFin;
        end
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Soft reset from the link behaves exactly like the hard reset.
    if (interboard_rst_i) begin
      state_d    = StIdle;
      target_d   = '0;
      cnt_d      = '0;
      idx_d      = '0;
      avail_d    = '0;
      hand_d     = '0;
      err_d      = 1'b0;
      draw_one_d = 1'b0;
      done_d     = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      target_q   <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      avail_q    <= '0;
      hand_q     <= '0;
      err_q      <= 1'b0;
      draw_one_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      avail_q    <= avail_d;
      hand_q     <= hand_d;
      err_q      <= err_d;
      draw_one_q <= draw_one_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign draw_one_o       = draw_one_q;
  assign available_card_o = avail_q;
  assign hand_o           = hand_q;
  assign dealt_cnt_o      = cnt_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_deal_cards.sv
// Self-checking bench for deal_cards: behavioural draw responder plus a set-based deal model.
module tb_deal_cards;
  import deal_cards_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                interboard_rst;
  logic                start;
  logic [CntW-1:0]     req_num;
  logic [DeckSize-1:0] pool_in;
  logic                draw_ready;
  logic                draw_done;
  logic [IdxW-1:0]     drawn_card_idx;
  logic                draw_one;
  logic [DeckSize-1:0] available_card;
  logic [DeckSize-1:0] hand;
  logic [CntW-1:0]     dealt_cnt;
  logic                busy;
  logic                done;
  logic                err;

  int checks = 0;
  int errors = 0;

  // Responder and monitor state
  logic ready_en = 1'b1;
  logic resp_busy = 1'b0;
  logic resp_hang = 1'b0;
  logic ready_at_edge = 1'b1;
  int   resp_wait = 0;
  int   resp_idx = 0;
  int   resp_q[$];
  int   done_cnt = 0;
  int   draw_one_cnt = 0;
  int   proto_err = 0;

  always #5 clk = ~clk;

  deal_cards dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .interboard_rst_i (interboard_rst),
    .start_i          (start),
    .req_num_i        (req_num),
    .pool_in_i        (pool_in),
    .draw_ready_i     (draw_ready),
    .draw_done_i      (draw_done),
    .drawn_card_idx_i (drawn_card_idx),
    .draw_one_o       (draw_one),
    .available_card_o (available_card),
    .hand_o           (hand),
    .dealt_cnt_o      (dealt_cnt),
    .busy_o           (busy),
    .done_o           (done),
    .err_o            (err)
  );

  assign draw_ready = ready_en && !resp_busy;

  always @(posedge clk) ready_at_edge = draw_ready;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (draw_one === 1'b1) begin
      draw_one_cnt++;
      if (!ready_at_edge) proto_err++;
    end
  end

  // Responder: accepts draw_one, waits 0..3 cycles, returns the next queued index.
  initial begin
    draw_done      = 1'b0;
    drawn_card_idx = '0;
    forever begin
      @(negedge clk);
      draw_done = 1'b0;
      if (resp_busy && !resp_hang) begin
        if (resp_wait != 0) begin
          resp_wait--;
        end else begin
          draw_done      = 1'b1;
          drawn_card_idx = IdxW'(resp_idx);
          resp_busy      = 1'b0;
        end
      end else if (!resp_busy && draw_one === 1'b1) begin
        resp_busy = 1'b1;
        resp_wait = int'($urandom_range(0, 3));
        resp_idx  = (resp_q.size() != 0) ? resp_q.pop_front() : int'(InvalidIdx);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  task automatic apply_reset();
    rst_n = 1'b0; interboard_rst = 1'b0; start = 1'b0; req_num = '0; pool_in = '0;
    ready_en = 1'b1; resp_hang = 1'b0; resp_busy = 1'b0; resp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_deal(input logic [DeckSize-1:0] pool, input int n);
    @(negedge clk);
    done_cnt = 0; draw_one_cnt = 0;
    pool_in = pool; req_num = CntW'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0; pool_in = '0; req_num = '0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_wait: done=%b after %0d cycles, expected 1", name, done, k);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (draw_one !== 1'b0) begin errors++; $display("FAIL reset_draw_one: got %b exp 0", draw_one); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++;
      $display("FAIL reset_flags: busy/done/err got %b%b%b exp 000", busy, done, err); end
    checks++; if (dealt_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", dealt_cnt); end
    checks++; if (hand !== '0 || available_card !== '0) begin errors++;
      $display("FAIL reset_bitmaps: hand=%h avail=%h exp 0", hand, available_card); end
  endtask

  task automatic test_full_deal();
    logic [DeckSize-1:0] mask = '0;
    for (int i = 0; i < 14; i++) begin resp_q.push_back(i); mask[i] = 1'b1; end
    start_deal('1, 14);
    wait_done("full");
    checks++; if (draw_one_cnt != 14) begin errors++; $display("FAIL full_draws: got %0d exp 14", draw_one_cnt); end
    checks++; if (hand !== mask) begin errors++; $display("FAIL full_hand: got %h exp %h", hand, mask); end
    checks++; if (available_card !== ~mask) begin errors++;
      $display("FAIL full_avail: got %h exp %h", available_card, ~mask); end
    checks++; if (dealt_cnt !== CntW'(14)) begin errors++; $display("FAIL full_cnt: got %0d exp 14", dealt_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err: got %b exp 0", err); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_count: got %0d exp 1", done_cnt); end
  endtask

  task automatic test_empty_pool();
    logic [DeckSize-1:0] pool = '0;
    pool[5] = 1'b1; pool[77] = 1'b1;
    resp_q.push_back(5); resp_q.push_back(77);
    start_deal(pool, 3);
    wait_done("empty");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL empty_err: got %b exp 1", err); end
    checks++; if (dealt_cnt !== CntW'(2)) begin errors++; $display("FAIL empty_cnt: got %0d exp 2", dealt_cnt); end
    checks++; if (hand !== pool || available_card !== '0) begin errors++;
      $display("FAIL empty_bitmaps: hand=%h avail=%h exp hand=%h avail=0", hand, available_card, pool); end
    checks++; if (done_cnt != 1 || draw_one_cnt != 2) begin errors++;
      $display("FAIL empty_pulses: done=%0d draws=%0d exp 1 and 2", done_cnt, draw_one_cnt); end
  endtask

  task automatic test_zero_request();
    @(negedge clk);
    done_cnt = 0; draw_one_cnt = 0;
    pool_in = '1; req_num = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL zero_cycle1: done=%b busy=%b exp done=0 busy=1", done, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_cycle2: done=%b exp 1", done); end
    repeat (3) @(negedge clk);
    checks++; if (draw_one_cnt != 0 || hand !== '0) begin errors++;
      $display("FAIL zero_nodraw: draws=%0d hand=%h exp 0 and 0", draw_one_cnt, hand); end
  endtask

  task automatic test_bad_index();
    logic [DeckSize-1:0] pool;
    logic [DeckSize-1:0] exp_hand = '0;
    int a;
    resp_q.push_back(int'(InvalidIdx));
    start_deal('1, 2);
    wait_done("bad110");
    checks++; if (err !== 1'b1 || dealt_cnt !== '0) begin errors++;
      $display("FAIL bad110_status: err=%b cnt=%0d exp 1 and 0", err, dealt_cnt); end
    checks++; if (hand !== '0 || available_card !== '1) begin errors++;
      $display("FAIL bad110_bitmaps: hand=%h avail=%h exp 0 and all ones", hand, available_card); end
    a = int'($urandom_range(0, DeckSize - 1));
    pool = '1; exp_hand[a] = 1'b1;
    resp_q.push_back(a); resp_q.push_back(a);
    start_deal(pool, 3);
    wait_done("baddup");
    checks++; if (err !== 1'b1 || dealt_cnt !== CntW'(1)) begin errors++;
      $display("FAIL baddup_status: err=%b cnt=%0d exp 1 and 1", err, dealt_cnt); end
    checks++; if (hand !== exp_hand || available_card !== (pool & ~exp_hand)) begin errors++;
      $display("FAIL baddup_bitmaps: hand=%h avail=%h exp hand=%h", hand, available_card, exp_hand); end
  endtask

  task automatic test_ready_low();
    logic [DeckSize-1:0] exp_hand = '0;
    exp_hand[3] = 1'b1;
    ready_en = 1'b0;
    resp_q.push_back(3);
    start_deal('1, 1);
    repeat (20) @(negedge clk);
    checks++; if (draw_one_cnt != 0 || busy !== 1'b1) begin errors++;
      $display("FAIL ready_low_hold: draws=%0d busy=%b exp 0 and 1", draw_one_cnt, busy); end
    ready_en = 1'b1;
    @(negedge clk);
    checks++; if (draw_one !== 1'b1) begin errors++; $display("FAIL ready_rise_pulse: draw_one=%b exp 1", draw_one); end
    wait_done("ready");
    checks++; if (draw_one_cnt != 1 || hand !== exp_hand) begin errors++;
      $display("FAIL ready_result: draws=%0d hand=%h exp 1 and %h", draw_one_cnt, hand, exp_hand); end
  endtask

  task automatic wait_first_draw(input string name);
    int k = 0;
    while (draw_one_cnt == 0 && k < 100) begin @(negedge clk); k++; end
    checks++; if (draw_one_cnt == 0) begin errors++; $display("FAIL %s_no_draw: draws=0 exp 1", name); end
  endtask

  task automatic test_async_reset();
    logic [DeckSize-1:0] exp_hand = '0;
    exp_hand[9] = 1'b1;
    resp_hang = 1'b1;
    start_deal('1, 3);
    wait_first_draw("arst");
    #3 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || draw_one !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++;
      $display("FAIL arst_flags: busy=%b draw=%b done=%b err=%b exp all 0", busy, draw_one, done, err); end
    checks++; if (hand !== '0 || available_card !== '0 || dealt_cnt !== '0) begin errors++;
      $display("FAIL arst_state: hand=%h avail=%h cnt=%0d exp 0", hand, available_card, dealt_cnt); end
    rst_n = 1'b1; resp_hang = 1'b0; resp_busy = 1'b0;
    resp_q.push_back(9);
    start_deal('1, 1);
    wait_done("arst_after");
    checks++; if (hand !== exp_hand || dealt_cnt !== CntW'(1) || err !== 1'b0) begin errors++;
      $display("FAIL arst_after: hand=%h cnt=%0d err=%b exp %h 1 0", hand, dealt_cnt, err, exp_hand); end
  endtask

  task automatic test_soft_reset();
    resp_hang = 1'b1;
    start_deal('1, 5);
    wait_first_draw("srst");
    interboard_rst = 1'b1;
    @(negedge clk);
    interboard_rst = 1'b0;
    checks++; if (busy !== 1'b0 || available_card !== '0 || hand !== '0 || dealt_cnt !== '0) begin errors++;
      $display("FAIL srst_state: busy=%b avail=%h hand=%h cnt=%0d exp 0", busy, available_card, hand, dealt_cnt); end
    resp_hang = 1'b0; resp_busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [127:0]        r1, r2, r3;
    logic [DeckSize-1:0] pool, exp_hand;
    int bits[$];
    int req, total, n_deal, j;
    logic exp_err;
    for (int it = 0; it < 10; it++) begin
      r1 = {$urandom, $urandom, $urandom, $urandom};
      pool = r1[DeckSize-1:0];
      if ($urandom_range(0, 1) == 1) begin
        r2 = {$urandom, $urandom, $urandom, $urandom};
        r3 = {$urandom, $urandom, $urandom, $urandom};
        pool = pool & r2[DeckSize-1:0] & r3[DeckSize-1:0] & r3[DeckSize+7:8];
      end
      req = int'($urandom_range(0, 20));
      bits.delete();
      for (int i = 0; i < DeckSize; i++) if (pool[i]) bits.push_back(i);
      total = bits.size();
      n_deal = (req < total) ? req : total;
      exp_err = (req > total);
      exp_hand = '0;
      resp_q.delete();
      for (int k = 0; k < n_deal; k++) begin
        j = int'($urandom_range(0, bits.size() - 1));
        resp_q.push_back(bits[j]);
        exp_hand[bits[j]] = 1'b1;
        bits.delete(j);
      end
      start_deal(pool, req);
      wait_done("rand");
      checks++; if (hand !== exp_hand) begin errors++;
        $display("FAIL rand%0d_hand: got %h exp %h", it, hand, exp_hand); end
      checks++; if (available_card !== (pool & ~exp_hand)) begin errors++;
        $display("FAIL rand%0d_avail: got %h exp %h", it, available_card, pool & ~exp_hand); end
      checks++; if (dealt_cnt !== CntW'(n_deal) || err !== exp_err) begin errors++;
        $display("FAIL rand%0d_status: cnt=%0d err=%b exp %0d %b", it, dealt_cnt, err, n_deal, exp_err); end
      checks++; if (draw_one_cnt != n_deal || done_cnt != 1) begin errors++;
        $display("FAIL rand%0d_pulses: draws=%0d done=%0d exp %0d 1", it, draw_one_cnt, done_cnt, n_deal); end
    end
  endtask

`ifdef DEAL_TIMEOUT_EN
  task automatic test_timeout();
    int k = 0;
    resp_hang = 1'b1;
    start_deal('1, 1);
    wait_first_draw("tmo");
    while (done !== 1'b1 && k < 5000) begin @(negedge clk); k++; end
    checks++; if (done !== 1'b1 || err !== 1'b1 || k < 4095 || k > 4096) begin errors++;
      $display("FAIL tmo_expiry: done=%b err=%b after %0d cycles exp 1 1 within 4095..4096", done, err, k); end
    resp_hang = 1'b0; resp_busy = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  task automatic test_protocol();
    checks++; if (proto_err != 0) begin errors++;
      $display("FAIL proto_draw_without_ready: got %0d violations exp 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_full_deal();
    test_empty_pool();
    test_zero_request();
    test_bad_index();
    test_ready_low();
    test_async_reset();
    test_soft_reset();
    test_random();
`ifdef DEAL_TIMEOUT_EN
    test_timeout();
`endif
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
